// File: rtl/gray_onehot_decoder.sv
// Registered decoder for the 3-bit gray / 7-bit one-hot-with-zero code words, with valid/ready on both sides.
// Optional macro GOH_DEC_DROP_ERR_EN: malformed words are counted but never presented downstream.
module gray_onehot_decoder #(
  parameter int USE_GRAY  = 1,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           code_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           bin_out,
  output logic                 code_err,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Returned as {err, bin[2:0]}.
  function automatic logic [3:0] decode_gray(input logic [6:0] c);
    return {|c[6:3], c[2], c[2] ^ c[1], c[2] ^ c[1] ^ c[0]};
  endfunction

  function automatic logic [3:0] decode_onehot(input logic [6:0] c);
    logic [2:0] idx;
    int         ones;
    idx  = '0;
    ones = 0;
    for (int i = 0; i < 7; i++) begin
      if (c[i]) begin
        ones++;
        idx = 3'(i + 1);
      end
    end
    if (ones > 1) return 4'b1000;
    return {1'b0, idx};
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Stage p0: combinational decode of the incoming word
  logic [3:0] dec_p0;
  logic [2:0] dec_bin_p0;
  logic       dec_err_p0;
  logic       accept_p0;
  logic       load_p0;

  assign dec_p0     = (USE_GRAY != 0) ? decode_gray(code_in) : decode_onehot(code_in);
  assign dec_bin_p0 = dec_p0[2:0];
  assign dec_err_p0 = dec_p0[3];

  assign in_ready  = !out_valid || out_ready;
  assign accept_p0 = in_valid && in_ready;

`ifdef GOH_DEC_DROP_ERR_EN
  // A dropped word still drains the register when downstream is ready, so code_err can never load a 1.
  assign load_p0 = accept_p0 && !dec_err_p0;
`else
  assign load_p0 = accept_p0;
`endif

  // Stage p1: single-entry output register and error counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      bin_out   <= '0;
      code_err  <= 1'b0;
      err_count <= '0;
    end else begin
      if (load_p0) begin
        out_valid <= 1'b1;
        bin_out   <= dec_bin_p0;
        code_err  <= dec_err_p0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (clr_err) begin
        err_count <= '0;
      end else if (accept_p0 && dec_err_p0) begin
        err_count <= sat_inc(err_count);
      end
    end
  end

endmodule

// File: tb/tb_gray_onehot_decoder.sv
// Scoreboard bench for gray_onehot_decoder: three instances (gray/8, one-hot/8, gray/2) share one stimulus stream.
module tb_gray_onehot_decoder;

  typedef struct packed {
    logic [2:0] bin;
    logic       err;
  } exp_t;

`ifdef GOH_DEC_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [6:0] code_in = '0;

  logic [2:0]      ov, ir, ce;
  logic [2:0][2:0] bo;
  logic [7:0]      ec0, ec1;
  logic [1:0]      ec2;

  exp_t q[3][$];
  int   cnt[3];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   rst_seen = 1'b0;

  gray_onehot_decoder #(.USE_GRAY(1), .ERR_CNT_W(8)) u_gray (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .code_in(code_in),
    .out_valid(ov[0]), .out_ready(out_ready), .bin_out(bo[0]), .code_err(ce[0]),
    .clr_err(clr_err), .err_count(ec0));

  gray_onehot_decoder #(.USE_GRAY(0), .ERR_CNT_W(8)) u_onehot (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .code_in(code_in),
    .out_valid(ov[1]), .out_ready(out_ready), .bin_out(bo[1]), .code_err(ce[1]),
    .clr_err(clr_err), .err_count(ec1));

  gray_onehot_decoder #(.USE_GRAY(1), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .code_in(code_in),
    .out_valid(ov[2]), .out_ready(out_ready), .bin_out(bo[2]), .code_err(ce[2]),
    .clr_err(clr_err), .err_count(ec2));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ec_of(input int d);
    case (d)
      0:       return int'(ec0);
      1:       return int'(ec1);
      default: return int'(ec2);
    endcase
  endfunction

  function automatic int cnt_max(input int d);
    return (d == 2) ? 3 : 255;
  endfunction

  // Reference: gray-to-binary by shifting XORs; one-hot by matching against powers of two.
  function automatic exp_t ref_decode(input bit gray, input logic [6:0] c);
    exp_t r;
    int   v, g;
    v = int'(c);
    r = '0;
    if (gray) begin
      g     = v & 7;
      r.bin = 3'(g ^ (g >> 1) ^ (g >> 2));
      r.err = (v >> 3) != 0;
    end else if (v != 0) begin
      r.err = 1'b1;
      for (int i = 0; i < 7; i++) begin
        if (v == (1 << i)) begin
          r.err = 1'b0;
          r.bin = 3'(i + 1);
        end
      end
    end
    return r;
  endfunction

  // Called at posedge+1; inputs apply to the next edge, the model is updated right after it.
  task automatic cycle(input logic v, input logic [6:0] c, input logic ordy, input logic clr);
    bit   acc[3];
    exp_t e;
    in_valid  = v;
    code_in   = c;
    out_ready = ordy;
    clr_err   = clr;
    for (int d = 0; d < 3; d++) acc[d] = rst_n && v && (q[d].size() == 0 || ordy);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        q[d].delete();
        cnt[d] = 0;
      end else begin
        e = ref_decode(d != 1, c);
        if (clr) cnt[d] = 0;
        else if (acc[d] && e.err) cnt[d] = (cnt[d] + 1 > cnt_max(d)) ? cnt_max(d) : cnt[d] + 1;
        if (acc[d] && !(DROP && e.err)) q[d].push_back(e);
      end
    end
    rst_seen = !rst_n;
  endtask

  // Monitor: at negedge, compare what each DUT presents against its scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        check($sformatf("out_valid[%0d]", d), int'(ov[d]), int'(q[d].size() != 0));
        check($sformatf("in_ready[%0d]", d), int'(ir[d]), int'(q[d].size() == 0 || out_ready));
        check($sformatf("err_count[%0d]", d), ec_of(d), cnt[d]);
        if (rst_seen) begin
          check($sformatf("rst_bin_out[%0d]", d), int'(bo[d]), 0);
          check($sformatf("rst_code_err[%0d]", d), int'(ce[d]), 0);
        end
        if (ov[d] && q[d].size() != 0) begin
          check($sformatf("bin_out[%0d]", d), int'(bo[d]), int'(q[d][0].bin));
          check($sformatf("code_err[%0d]", d), int'(ce[d]), int'(q[d][0].err));
          if (out_ready) void'(q[d].pop_front());
        end
      end
    end
  end

  logic [6:0] gray_seq[8]   = '{7'h00, 7'h01, 7'h03, 7'h02, 7'h06, 7'h07, 7'h05, 7'h04};
  logic [6:0] onehot_seq[8] = '{7'h00, 7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40};
  int         sat_exp[5]    = '{1, 2, 3, 3, 3};

  initial begin
    logic [6:0] c;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    code_in   = 7'h7F;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_en   = 1'b1;
    rst_seen = 1'b1;
    cycle(1'b1, 7'h7F, 1'b0, 1'b0);
    rst_n = 1'b1;
    check("in_ready_after_reset", int'(ir[0]), 1);
    check("out_valid_after_reset", int'(ov[0]), 0);

    foreach (gray_seq[i]) cycle(1'b1, gray_seq[i], 1'b1, 1'b0);
    cycle(1'b0, 7'h00, 1'b1, 1'b1);

    foreach (onehot_seq[i]) cycle(1'b1, onehot_seq[i], 1'b1, 1'b0);
    cycle(1'b1, 7'h03, 1'b1, 1'b0);
    check("onehot_err_count", int'(ec1), 1);
    cycle(1'b0, 7'h00, 1'b1, 1'b0);

    cycle(1'b1, 7'h06, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 7'h01, 1'b0, 1'b0);
      check("hold_out_valid", int'(ov[0]), 1);
      check("hold_bin_out", int'(bo[0]), 4);
      check("hold_in_ready", int'(ir[0]), 0);
    end
    cycle(1'b1, 7'h07, 1'b1, 1'b0);
    check("replace_bin_out", int'(bo[0]), 5);
    cycle(1'b0, 7'h00, 1'b1, 1'b0);

    cycle(1'b1, 7'h05, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b0, 7'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 7'h00, 1'b1, 1'b0);

    cycle(1'b0, 7'h00, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 7'h08, 1'b1, 1'b0);
      check($sformatf("sat_count_%0d", k), int'(ec2), sat_exp[k]);
    end
    cycle(1'b1, 7'h08, 1'b1, 1'b1);
    check("sat_clear", int'(ec2), 0);

    cycle(1'b1, 7'h10, 1'b1, 1'b0);
    cycle(1'b1, 7'h02, 1'b1, 1'b0);
    cycle(1'b0, 7'h00, 1'b1, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    c = 7'($urandom_range(0, 7));
        2:       c = 7'(1 << $urandom_range(0, 6));
        default: c = 7'($urandom_range(0, 127));
      endcase
      rst_n = ($urandom_range(0, 199) != 0);
      cycle($urandom_range(0, 3) != 0, c, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 7'h00, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_onehot_decoder.md
Name: gray_onehot_decoder

Overview:
- Registered downstream stage that consumes the 7-bit gray/one-hot code word produced by the 3-bit code generator.
- Recovers the original 3-bit value, flags malformed code words and keeps a saturating error count.
- Sits between the code generator and the next consumer, with valid/ready handshakes on both sides.
- Single-entry output register; no combinational path from code_in to bin_out.

Parameters:
- USE_GRAY, 1: 1 = decode 3-bit gray code in code_in[2:0]; 0 = decode the 7-bit one-hot-with-zero code.
- ERR_CNT_W, 8: width of err_count, legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream presents code_in.
- in_ready  output  1  block can accept a code word this cycle.
- code_in  input  7  code word from the generator.
- out_valid  output  1  bin_out/code_err hold a decoded word.
- out_ready  input  1  downstream accepts the held word.
- bin_out  output  3  decoded binary value.
- code_err  output  1  held word was malformed.
- clr_err  input  1  synchronous clear of err_count.
- err_count  output  ERR_CNT_W  saturating count of accepted malformed words.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, bin_out=0, code_err=0, err_count=0. in_ready=1 in the cycle after reset.
- Reset mid-transfer discards the held word; nothing is replayed.
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. On accept, the decoded word loads the output register and out_valid=1 next cycle (latency 1).
- Back-to-back: if out_valid && out_ready && in_valid, a new word replaces the held one in the same edge, giving full throughput.
- If out_valid && out_ready && !in_valid, out_valid goes to 0.
- If out_valid && !out_ready, the output register and its outputs are held stable and in_ready=0.
- Gray decode (USE_GRAY=1):
  - bin[2]=c[2]; bin[1]=c[2]^c[1]; bin[0]=c[2]^c[1]^c[0].
  - Error if c[6:3]!=0; bin_out is still the decode of c[2:0].
- One-hot decode (USE_GRAY=0):
  - c=0 -> 0.
  - Exactly one bit i set (i=0..6) -> i+1.
  - Any other pattern -> error, bin_out=0.
  - Note: both c=0 and c=0000001 are legal and decode to 0 and 1 respectively.
- Error counter:
  - Increments by 1 on each accepted malformed word.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - clr_err=1 sets err_count to 0 next cycle and takes priority over a simultaneous increment; that error is not counted.
  - clr_err has no effect on the handshake or on the output register.
- No states beyond EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready without accept.
  - FULL -> FULL on hold, or on accept together with drain.

Optional Feature:
- Macro: GOH_DEC_DROP_ERR_EN.
- Defined: malformed words are accepted and counted but never loaded into the output register.
  - The register is treated as drained if out_ready is set, otherwise held unchanged.
  - out_valid never rises for a malformed word.
  - code_err is tied to 0.
- Undefined: malformed words are passed downstream with code_err=1, as described above.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1, code_in=7'h7F -> out_valid=0, err_count=0, bin_out=0; in_ready=1 after release.
- Gray sweep (USE_GRAY=1, out_ready=1): stream code_in = 0,1,3,2,6,7,5,4 on consecutive cycles -> bin_out 0..7 one cycle later each, code_err=0, no bubbles.
- One-hot sweep (USE_GRAY=0): stream 7'h00,7'h01,7'h02,7'h04,7'h08,7'h10,7'h20,7'h40 -> bin_out 0..7.
  - Then 7'h03 -> bin_out=0, code_err=1, err_count=1.
- Backpressure: hold out_ready=0 after accepting gray 7'h06 -> bin_out=4 and out_valid held for 5 cycles, in_ready=0.
  - Then assert out_ready with in_valid=1, code_in=7'h07 -> same-edge replace, bin_out=5.
- Saturation (ERR_CNT_W=2, USE_GRAY=1): send 5 words with code_in=7'h08 -> err_count 1,2,3,3,3.
  - Assert clr_err in the same cycle as a 6th error -> err_count=0.
- GOH_DEC_DROP_ERR_EN defined: send 7'h10, 7'h02 (gray) -> only bin_out=3 emitted, err_count=1, code_err never 1.
